fpu_wb_queue: RTL

FPU_WB_QUEUE -- requirements
Module: fpu_wb_queue

---
 rtl/fpu_pkg.sv | 15 +
 rtl/fpu_wb_fifo2w.sv | 64 ++++++
 rtl/fpu_wb_queue.sv | 108 ++++++++++
 3 files changed

// File: rtl/fpu_pkg.sv
// Shared types and constants for the FPU conversion-unit writeback path.
// The itof and ftoi conversion units share one register-file writeback port.
package fpu_pkg;

    localparam int TAGW_DEFAULT = 5;
    localparam int ITOF_LAT     = 4;
    localparam int FTOI_LAT     = 3;

    typedef struct packed {
        logic [31:0]             data;
        logic [TAGW_DEFAULT-1:0] rd;
        logic                    is_int;
    } wb_entry_t;

endpackage

// File: rtl/fpu_wb_fifo2w.sv
// Result storage with two write ports and one read port.
// The write ports must be compacted: we1 may only be set when we0 is also set.
module fpu_wb_fifo2w
    import fpu_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type T     = wb_entry_t
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we0,
    input  T                         wd0,
    input  logic                     we1,
    input  T                         wd1,
    input  logic                     pop,
    output T                         rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic [$clog2(DEPTH):0]   count_nxt
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    T                mem_r [DEPTH];
    logic [PW-1:0]   wr_ptr_r;
    logic [PW-1:0]   rd_ptr_r;
    logic [CW-1:0]   count_r;
    logic [CW-1:0]   count_nxt_s;
    logic [PW-1:0]   wr_adv_s;

    // Next occupancy and write-pointer advance from this cycle's pushes and pop.
    always_comb begin
        count_nxt_s = count_r + CW'(we0) + CW'(we1) - CW'(pop);
        wr_adv_s    = PW'(we0) + PW'(we1);
    end

    // Pointer and occupancy state; reset empties the queue immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            wr_ptr_r <= wr_ptr_r + wr_adv_s;
            rd_ptr_r <= rd_ptr_r + PW'(pop);
            count_r  <= count_nxt_s;
        end
    end

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (we0) begin
            mem_r[wr_ptr_r] <= wd0;
        end
        if (we1) begin
            mem_r[wr_ptr_r + PW'(1)] <= wd1;
        end
    end

    assign rd_data   = mem_r[rd_ptr_r];
    assign count     = count_r;
    assign count_nxt = count_nxt_s;

endmodule

// File: rtl/fpu_wb_queue.sv
// Writeback queue merging itof and ftoi results onto one register-file port.
// Holds push ordering, drop/overflow detection and the issue stall.
module fpu_wb_queue
    import fpu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TAGW  = TAGW_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            itof_valid,
    input  logic [31:0]     itof_y,
    input  logic [TAGW-1:0] itof_rd,
    input  logic            ftoi_valid,
    input  logic [31:0]     ftoi_y,
    input  logic [TAGW-1:0] ftoi_rd,
    output logic            wb_valid,
    output logic [31:0]     wb_data,
    output logic [TAGW-1:0] wb_rd,
    output logic            wb_is_int,
    input  logic            wb_ready,
    output logic            fpu_stall,
    output logic            overflow
);

    localparam int CW = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [31:0]     data;
        logic [TAGW-1:0] rd;
        logic            is_int;
    } entry_t;

    entry_t          itof_e_s;
    entry_t          ftoi_e_s;
    entry_t          wd0_s;
    entry_t          wd1_s;
    entry_t          head_s;
    logic            we0_s;
    logic            we1_s;
    logic            pop_s;
    logic            itof_acc_s;
    logic            ftoi_acc_s;
    logic            drop_s;
    logic [CW-1:0]   free_s;
    logic [CW-1:0]   count_s;
    logic [CW-1:0]   count_nxt_s;
    logic            fpu_stall_r;
    logic            overflow_r;

    // Acceptance and slot ordering: itof always claims space first and the lower slot.
    always_comb begin
        pop_s    = wb_valid & wb_ready;
        free_s   = CW'(DEPTH) - count_s + CW'(pop_s);
        itof_e_s = '{data: itof_y, rd: itof_rd, is_int: 1'b0};
        ftoi_e_s = '{data: ftoi_y, rd: ftoi_rd, is_int: 1'b1};
        itof_acc_s = itof_valid & (free_s >= CW'(1));
        if (itof_acc_s) begin
            ftoi_acc_s = ftoi_valid & (free_s >= CW'(2));
        end else begin
            ftoi_acc_s = ftoi_valid & (free_s >= CW'(1));
        end
        drop_s = (itof_valid & ~itof_acc_s) | (ftoi_valid & ~ftoi_acc_s);
        we0_s  = itof_acc_s | ftoi_acc_s;
        we1_s  = itof_acc_s & ftoi_acc_s;
        if (itof_acc_s) begin
            wd0_s = itof_e_s;
        end else begin
            wd0_s = ftoi_e_s;
        end
        wd1_s = ftoi_e_s;
    end

    fpu_wb_fifo2w #(
        .DEPTH (DEPTH),
        .T     (entry_t)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .we0       (we0_s),
        .wd0       (wd0_s),
        .we1       (we1_s),
        .wd1       (wd1_s),
        .pop       (pop_s),
        .rd_data   (head_s),
        .count     (count_s),
        .count_nxt (count_nxt_s)
    );

    // Stall leaves two free slots so a dual push already in flight still fits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fpu_stall_r <= 1'b0;
            overflow_r  <= 1'b0;
        end else begin
            fpu_stall_r <= (count_nxt_s >= CW'(DEPTH - 2));
            overflow_r  <= overflow_r | drop_s;
        end
    end

    assign wb_valid  = (count_s != {CW{1'b0}});
    assign wb_data   = head_s.data;
    assign wb_rd     = head_s.rd;
    assign wb_is_int = head_s.is_int;
    assign fpu_stall = fpu_stall_r;
    assign overflow  = overflow_r;

endmodule
